// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmit sequencer: FSM state encoding,
// default word length and a constant-foldable ceiling-log2 for counter sizing.
package serial_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 32'sd16;

   // Never returns less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int result;
      result = 32'sd1;
      while ((32'sd1 << result) < value) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out register, MSB first; a load wins over a shift so a
// back-to-back reload on the last bit of a frame replaces the drained word.
module piso_shift_reg #(
   parameter int WIDTH = 32'sd16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] data_in,
   output logic             q_msb
);

   logic [WIDTH-1:0] shift_r;

   // Load, shift left with zero fill, or hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_r <= {WIDTH{1'b0}};
      end else if (load) begin
         shift_r <= data_in;
      end else if (shift_en) begin
         shift_r <= {shift_r[WIDTH-2:0], 1'b0};
      end else begin
         shift_r <= shift_r;
      end
   end

   assign q_msb = shift_r[WIDTH-1];

endmodule

// File: rtl/serial_tx_sequencer.sv
// Sequences a PISO datapath: accepts words over valid/ready, emits them MSB
// first with an optional idle gap, and counts completed frames.
module serial_tx_sequencer
   import serial_tx_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int GAP_CYCLES = 32'sd1,
   parameter int CNT_W      = 32'sd8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy,
   output logic [CNT_W-1:0] frames_sent
);

   localparam int                BIT_W    = clog2(WIDTH);
   localparam int                GAP_W    = clog2(GAP_CYCLES + 32'sd1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WIDTH - 32'sd1);
   localparam logic [GAP_W-1:0]  LAST_GAP = GAP_W'(GAP_CYCLES - 32'sd1);
   localparam bit                HAS_GAP  = (GAP_CYCLES > 32'sd0);

   state_e            state_r, state_s;
   logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
   logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
   logic [CNT_W-1:0]  frames_r, frames_s;
   logic              load_s, shift_s, accept_s;
   logic              in_ready_r, ser_valid_r, frame_start_r, frame_done_r, busy_r;

   // Ready depends only on where the FSM sits, never on in_valid.
   function automatic logic ready_of(input state_e st, input logic [BIT_W-1:0] cnt);
      return (st == ST_IDLE) || (!HAS_GAP && (st == ST_SHIFT) && (cnt == LAST_BIT));
   endfunction

   assign accept_s = in_valid && in_ready_r;

   // Next-state, counter and datapath-control decode.
   always_comb begin
      state_s   = state_r;
      bit_cnt_s = bit_cnt_r;
      gap_cnt_s = gap_cnt_r;
      frames_s  = frames_r;
      load_s    = 1'b0;
      shift_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               load_s    = 1'b1;
               bit_cnt_s = {BIT_W{1'b0}};
               state_s   = ST_SHIFT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_s   = 1'b1;
            bit_cnt_s = bit_cnt_r + BIT_W'(1'b1);
            if (bit_cnt_r == LAST_BIT) begin
               frames_s = frames_r + CNT_W'(1'b1);
               if (HAS_GAP) begin
                  state_s   = ST_GAP;
                  gap_cnt_s = {GAP_W{1'b0}};
               end else if (accept_s) begin
                  load_s    = 1'b1;
                  bit_cnt_s = {BIT_W{1'b0}};
                  state_s   = ST_SHIFT;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_GAP: begin
            gap_cnt_s = gap_cnt_r + GAP_W'(1'b1);
            if (gap_cnt_r == LAST_GAP) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and status flags registered from their next values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         bit_cnt_r     <= {BIT_W{1'b0}};
         gap_cnt_r     <= {GAP_W{1'b0}};
         frames_r      <= {CNT_W{1'b0}};
         in_ready_r    <= 1'b1;
         ser_valid_r   <= 1'b0;
         frame_start_r <= 1'b0;
         frame_done_r  <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         bit_cnt_r     <= bit_cnt_s;
         gap_cnt_r     <= gap_cnt_s;
         frames_r      <= frames_s;
         in_ready_r    <= ready_of(state_s, bit_cnt_s);
         ser_valid_r   <= (state_s == ST_SHIFT);
         frame_start_r <= (state_s == ST_SHIFT) && (bit_cnt_s == {BIT_W{1'b0}});
         frame_done_r  <= (state_s == ST_SHIFT) && (bit_cnt_s == LAST_BIT);
         busy_r        <= (state_s != ST_IDLE);
      end
   end

   piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s),
      .shift_en (shift_s),
      .data_in  (in_data),
      .q_msb    (ser_out)
   );

   assign in_ready    = in_ready_r;
   assign ser_valid   = ser_valid_r;
   assign frame_start = frame_start_r;
   assign frame_done  = frame_done_r;
   assign busy        = busy_r;
   assign frames_sent = frames_r;

endmodule
